// File: rtl/lcd_bus_monitor.sv
// lcd_bus_monitor: receive-side shadow of an HD44780 8-bit LCD bus.
// Ports: lcd_e/rs/rw/data are the raw bus; rd_addr/rd_char read the 2x16 shadow
// buffer; evt_* is one pulse per accepted strobe; ddram_addr and the
// display/entry/function flags mirror controller state; busy covers a clear;
// err_flags are sticky (short E, strobe while busy, read, bad address),
// cleared by err_clr.
module lcd_bus_monitor #(
  parameter int MIN_E_HIGH = 4,
  parameter int CLEAR_CYC  = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       evt_valid,
  output logic       evt_rs,
  output logic [7:0] evt_data,
  output logic [6:0] ddram_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       func_8bit,
  output logic       func_2line,
  output logic       busy,
  output logic [3:0] err_flags,
  input  logic       err_clr
);
  localparam int HW = $clog2(MIN_E_HIGH + 1);
  localparam int CW = $clog2(CLEAR_CYC + 1);
  // {e, rs, rw, data} travel through the synchronizer together so they stay aligned
  logic [10:0] s1_q, s1_d, s2_q, s2_d;
  logic        ep_q, ep_d;
  logic [HW-1:0] high_q, high_d;
  logic        evt_valid_q, evt_valid_d, evt_rs_q, evt_rs_d;
  logic [7:0]  evt_data_q, evt_data_d;
  logic [7:0]  mem_q [32];
  logic [7:0]  mem_d [32];
  logic [6:0]  addr_q, addr_d;
  logic        disp_q, disp_d, cur_q, cur_d, blk_q, blk_d, inc_q, inc_d;
  logic        f8_q, f8_d, f2_q, f2_d, cg_q, cg_d, busy_q, busy_d;
  logic [CW-1:0] clr_q, clr_d;
  logic [3:0]  err_q, err_d;
  logic        fall, long_e, acc, rs_s, rw_s;
  logic [7:0]  dat_s;

  function automatic logic [6:0] step(input logic [6:0] a, input logic inc);
    return inc ? (a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1)
               : (a == 7'h40 ? 7'h27 : a == 7'h00 ? 7'h67 : a - 7'd1);
  endfunction

  function automatic logic addr_ok(input logic [6:0] a);
    return a <= 7'h27 || (a >= 7'h40 && a <= 7'h67);
  endfunction

  assign rs_s   = s2_q[9];
  assign rw_s   = s2_q[8];
  assign dat_s  = s2_q[7:0];
  assign fall   = ep_q && !s2_q[10];
  assign long_e = high_q >= HW'(MIN_E_HIGH);
  assign acc    = fall && long_e;

  always_comb begin
    s1_d = {lcd_e, lcd_rs, lcd_rw, lcd_data};
    s2_d = s1_q;
    ep_d = s2_q[10];
    high_d = !s2_q[10] ? '0 : high_q == HW'(MIN_E_HIGH) ? high_q : high_q + HW'(1);
    evt_valid_d = acc;
    evt_rs_d = acc ? rs_s : evt_rs_q;
    evt_data_d = acc ? dat_s : evt_data_q;
    mem_d = mem_q;
    addr_d = addr_q;
    disp_d = disp_q;
    cur_d = cur_q;
    blk_d = blk_q;
    inc_d = inc_q;
    f8_d = f8_q;
    f2_d = f2_q;
    cg_d = cg_q;
    busy_d = busy_q;
    clr_d = clr_q;
    // a flag raised in the same cycle as err_clr survives
    err_d = err_clr ? 4'h0 : err_q;
    if (fall && !long_e) err_d[0] = 1'b1;
    if (busy_q) begin
      if (clr_q < CW'(32)) mem_d[clr_q[4:0]] = 8'h20;
      clr_d = clr_q + CW'(1);
      if (clr_q == CW'(CLEAR_CYC - 1)) begin
        busy_d = 1'b0;
        addr_d = 7'h00;
        inc_d = 1'b1;
        cg_d = 1'b0;
      end
    end
    if (acc) begin
      if (rw_s) err_d[2] = 1'b1;
      else if (busy_q) err_d[1] = 1'b1;
      else if (rs_s) begin
        if (!cg_q) begin
          // only columns 0..15 of each line are visible and stored
          if (addr_q[5:4] == 2'b00) mem_d[{addr_q[6], addr_q[3:0]}] = dat_s;
          addr_d = step(addr_q, inc_q);
        end
      end else if (dat_s[7]) begin
        cg_d = 1'b0;
        addr_d = addr_ok(dat_s[6:0]) ? dat_s[6:0] : 7'h00;
        if (!addr_ok(dat_s[6:0])) err_d[3] = 1'b1;
      end else if (dat_s[6]) cg_d = 1'b1;
      else if (dat_s[5]) begin
        f8_d = dat_s[4];
        f2_d = dat_s[3];
      end else if (!dat_s[4]) begin
        if (dat_s[3]) begin
          disp_d = dat_s[2];
          cur_d = dat_s[1];
          blk_d = dat_s[0];
        end else if (dat_s[2]) inc_d = dat_s[1];
        else if (dat_s[1]) begin
          addr_d = 7'h00;
          cg_d = 1'b0;
        end else if (dat_s[0]) begin
          busy_d = 1'b1;
          clr_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q <= '0;
      s2_q <= '0;
      ep_q <= 1'b0;
      high_q <= '0;
      evt_valid_q <= 1'b0;
      evt_rs_q <= 1'b0;
      evt_data_q <= 8'h00;
      for (int i = 0; i < 32; i++) mem_q[i] <= 8'h20;
      addr_q <= 7'h00;
      disp_q <= 1'b0;
      cur_q <= 1'b0;
      blk_q <= 1'b0;
      inc_q <= 1'b1;
      f8_q <= 1'b0;
      f2_q <= 1'b0;
      cg_q <= 1'b0;
      busy_q <= 1'b0;
      clr_q <= '0;
      err_q <= 4'h0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      ep_q <= ep_d;
      high_q <= high_d;
      evt_valid_q <= evt_valid_d;
      evt_rs_q <= evt_rs_d;
      evt_data_q <= evt_data_d;
      mem_q <= mem_d;
      addr_q <= addr_d;
      disp_q <= disp_d;
      cur_q <= cur_d;
      blk_q <= blk_d;
      inc_q <= inc_d;
      f8_q <= f8_d;
      f2_q <= f2_d;
      cg_q <= cg_d;
      busy_q <= busy_d;
      clr_q <= clr_d;
      err_q <= err_d;
    end
  end

  assign rd_char = mem_q[rd_addr];
  assign evt_valid = evt_valid_q;
  assign evt_rs = evt_rs_q;
  assign evt_data = evt_data_q;
  assign ddram_addr = addr_q;
  assign disp_on = disp_q;
  assign cursor_on = cur_q;
  assign blink_on = blk_q;
  assign entry_inc = inc_q;
  assign func_8bit = f8_q;
  assign func_2line = f2_q;
  assign busy = busy_q;
  assign err_flags = err_q;
endmodule

// File: tb/tb_lcd_bus_monitor.sv
// tb_lcd_bus_monitor: scoreboard bench with a line/column reference model of the LCD shadow.
module tb_lcd_bus_monitor;
  localparam int MINH = 4;
  localparam int CLR = 32;
  logic clk = 0, resetn = 0, lcd_e = 0, lcd_rs = 0, lcd_rw = 0, err_clr = 0;
  logic [7:0] lcd_data = 0;
  logic [4:0] rd_addr = 0;
  logic [7:0] rd_char, evt_data;
  logic evt_valid, evt_rs, disp_on, cursor_on, blink_on, entry_inc, func_8bit, func_2line, busy;
  logic [6:0] ddram_addr;
  logic [3:0] err_flags;

  lcd_bus_monitor #(.MIN_E_HIGH(MINH), .CLEAR_CYC(CLR)) dut (
    .clk(clk), .resetn(resetn), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char), .evt_valid(evt_valid),
    .evt_rs(evt_rs), .evt_data(evt_data), .ddram_addr(ddram_addr), .disp_on(disp_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .entry_inc(entry_inc), .func_8bit(func_8bit),
    .func_2line(func_2line), .busy(busy), .err_flags(err_flags), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [8:0] exq[$];
  logic [7:0] m_mem[32];
  logic [6:0] m_addr;
  logic m_inc, m_disp, m_cur, m_blk, m_8, m_2, m_cg, m_busy;
  logic [3:0] m_err;
  int blen = 0, last_blen = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] m_next(input logic [6:0] a, input logic inc);
    int line = int'(a[6]);
    int col = int'(a[5:0]);
    if (inc) begin
      col++;
      if (col == 40) begin col = 0; line = 1 - line; end
    end else begin
      col--;
      if (col < 0) begin col = 39; line = 1 - line; end
    end
    return 7'(line * 64 + col);
  endfunction

  task automatic m_reset();
    foreach (m_mem[i]) m_mem[i] = 8'h20;
    m_addr = 0; m_inc = 1; m_disp = 0; m_cur = 0; m_blk = 0;
    m_8 = 0; m_2 = 0; m_cg = 0; m_busy = 0; m_err = 0;
  endtask

  task automatic m_apply(input logic rs, input logic rw, input logic [7:0] d, input int h);
    int a, col;
    if (h < MINH) begin m_err[0] = 1; return; end
    exq.push_back({rs, d});
    if (rw) m_err[2] = 1;
    else if (m_busy) m_err[1] = 1;
    else if (rs) begin
      if (!m_cg) begin
        col = int'(m_addr) % 64;
        if (col < 16) m_mem[(int'(m_addr) / 64) * 16 + col] = d;
        m_addr = m_next(m_addr, m_inc);
      end
    end else if (d >= 8'h80) begin
      a = int'(d) - 128;
      m_cg = 0;
      if (a <= 39 || (a >= 64 && a <= 103)) m_addr = 7'(a);
      else begin m_addr = 0; m_err[3] = 1; end
    end else if (d >= 8'h40) m_cg = 1;
    else if (d >= 8'h20) begin m_8 = d[4]; m_2 = d[3]; end
    else if (d >= 8'h10) begin end
    else if (d >= 8'h08) begin m_disp = d[2]; m_cur = d[1]; m_blk = d[0]; end
    else if (d >= 8'h04) m_inc = d[1];
    else if (d >= 8'h02) begin m_addr = 0; m_cg = 0; end
    else if (d == 8'h01) begin m_busy = 1; foreach (m_mem[i]) m_mem[i] = 8'h20; end
  endtask

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int h, input bit clr = 0);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d;
    repeat (2) @(negedge clk);
    lcd_e = 1;
    repeat (h) @(negedge clk);
    lcd_e = 0;
    if (clr) m_err = 0;
    m_apply(rs, rw, d, h);
    if (clr) begin
      repeat (2) @(negedge clk);
      err_clr = 1;
      @(negedge clk);
      err_clr = 0;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_clear();
    repeat (CLR + 10) @(negedge clk);
    m_addr = 0; m_inc = 1; m_cg = 0; m_busy = 0;
    chk("busy_len", last_blen, CLR);
  endtask

  task automatic check_state();
    chk("ddram_addr", ddram_addr, m_addr);
    chk("disp_on", disp_on, m_disp);
    chk("cursor_on", cursor_on, m_cur);
    chk("blink_on", blink_on, m_blk);
    chk("entry_inc", entry_inc, m_inc);
    chk("func_8bit", func_8bit, m_8);
    chk("func_2line", func_2line, m_2);
    chk("busy", busy, m_busy);
    chk("err_flags", err_flags, m_err);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      chk($sformatf("rd_char[%0d]", i), rd_char, m_mem[i]);
    end
  endtask

  always @(negedge clk) begin
    if (busy) blen++;
    else if (blen != 0) begin last_blen = blen; blen = 0; end
  end

  always @(negedge clk) begin
    if (resetn && evt_valid) begin
      if (exq.size() == 0) chk("evt_unexpected", evt_valid, 0);
      else chk("evt", {evt_rs, evt_data}, exq.pop_front());
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    string s1, s2;
    int r;
    logic [7:0] v;
    s1 = "EW:GREEN SN:RED ";
    s2 = "NS:RED  EW:GO   ";
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_rs", evt_rs, 0);
    chk("rst_evt_data", evt_data, 0);
    check_state();
    resetn = 1;
    // init sequence
    strobe(0, 0, 8'h01, 8);
    chk("busy_after_clear", busy, 1);
    wait_clear();
    strobe(0, 0, 8'h38, 8);
    strobe(0, 0, 8'h06, 8);
    strobe(0, 0, 8'h0C, 8);
    check_state();
    // two full lines
    strobe(0, 0, 8'h80, 6);
    for (int i = 0; i < 16; i++) strobe(1, 0, s1[i], 6);
    check_state();
    strobe(0, 0, 8'hC0, 6);
    for (int i = 0; i < 16; i++) strobe(1, 0, s2[i], 6);
    check_state();
    // line wrap and decrement wrap
    strobe(0, 0, 8'hA7, 6);
    strobe(1, 0, "X", 6);
    strobe(1, 0, "Y", 6);
    check_state();
    strobe(0, 0, 8'h04, 6);
    strobe(0, 0, 8'h80, 6);
    strobe(1, 0, "Z", 6);
    check_state();
    strobe(0, 0, 8'h06, 6);
    // E width boundary and err_clr
    strobe(1, 0, "q", 2);
    check_state();
    @(negedge clk); err_clr = 1; @(negedge clk); err_clr = 0; m_err = 0;
    check_state();
    strobe(1, 0, "r", MINH - 1);
    strobe(1, 0, "s", MINH);
    check_state();
    // strobe while busy, bad address, read strobe, clear racing a new error
    strobe(0, 0, 8'h01, 6);
    strobe(1, 0, "B", 6);
    wait_clear();
    check_state();
    strobe(0, 0, 8'hB0, 6);
    check_state();
    strobe(1, 1, "R", 6);
    check_state();
    strobe(1, 0, "t", 2, 1);
    check_state();
    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40) strobe(1, 0, 8'($urandom_range(32, 126)), $urandom_range(MINH, 8));
      else if (r < 50) begin
        v = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255))
          : 8'(128 + $urandom_range(0, 1) * 64 + $urandom_range(0, 39));
        strobe(0, 0, v, 6);
      end
      else if (r < 55) strobe(0, 0, 8'(4 + $urandom_range(0, 3)), 6);
      else if (r < 60) strobe(0, 0, 8'(8 + $urandom_range(0, 7)), 6);
      else if (r < 63) strobe(0, 0, 8'(32 + $urandom_range(0, 31)), 6);
      else if (r < 65) strobe(0, 0, 8'(16 + $urandom_range(0, 15)), 6);
      else if (r < 68) strobe(0, 0, 8'(2 + $urandom_range(0, 1)), 6);
      else if (r < 71) strobe(0, 0, 8'(64 + $urandom_range(0, 63)), 6);
      else if (r < 74) strobe($urandom_range(0, 1), 1, 8'($urandom), 6);
      else if (r < 79) strobe(1, 0, 8'($urandom), $urandom_range(1, MINH - 1));
      else if (r < 81) begin strobe(0, 0, 8'h01, 6); wait_clear(); end
      else if (r < 84) begin @(negedge clk); err_clr = 1; @(negedge clk); err_clr = 0; m_err = 0; end
      else strobe(1, 0, 8'($urandom_range(32, 126)), MINH);
      check_state();
    end
    // reset in the middle of a clear
    strobe(1, 0, "M", 6);
    strobe(0, 0, 8'h01, 6);
    chk("busy_mid_clear", busy, 1);
    resetn = 0;
    #1;
    chk("busy_async_rst", busy, 0);
    chk("evt_valid_rst", evt_valid, 0);
    chk("evt_rs_rst", evt_rs, 0);
    chk("evt_data_rst", evt_data, 0);
    m_reset();
    repeat (2) @(negedge clk);
    check_state();
    resetn = 1;
    repeat (4) @(negedge clk);
    chk("evt_pending", exq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
